// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM state encoding,
// transaction-owner codes and default bus widths.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 32;
  localparam int MEM_ARB_LINE_W = 128;

  localparam logic MEM_ARB_OWNER_I = 1'b0;
  localparam logic MEM_ARB_OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response channel used for both cache ports and the memory port.
// The master issues requests and receives responses; the slave serves them.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int LINE_W = MEM_ARB_LINE_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant selection between I- and D-cache requesters. D wins ties unless the
// optional starvation guard (MEM_ARB_STARVE_GUARD_EN) forces an I grant.
module mem_arb_grant
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic clk,
  input  logic rst_n,
  input  logic accept_i,
`endif
  input  logic i_valid_i,
  input  logic d_valid_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  logic starve_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign starve_s = (cnt_q == CNT_W'(STARVE_LIMIT));

  // Count D grants made while I was waiting; any I grant clears the count.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_i && grant_i_o) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_i && grant_d_o && i_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign starve_s = 1'b0;
`endif

  // D has priority unless I has been passed over STARVE_LIMIT times.
  always_comb begin
    grant_d_o = d_valid_i & ~(i_valid_i & starve_s);
    grant_i_o = i_valid_i & ~grant_d_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the memory port between I- and D-cache
// refill paths. Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = MEM_ARB_ADDR_W,
  parameter int LINE_W       = MEM_ARB_LINE_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   i_bus,
  mem_arbiter_if.slave   d_bus,
  mem_arbiter_if.master  mem_bus,
  output logic           owner_d
);

  mem_arb_state_t    state_q;
  mem_arb_state_t    state_d;
  logic              txn_owner_q;
  logic              txn_owner_d;
  logic              we_q;
  logic              we_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] wdata_d;
  logic              arb_en_q;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              accept_s;

  mem_arb_grant
`ifdef MEM_ARB_STARVE_GUARD_EN
  #(
    .STARVE_LIMIT (STARVE_LIMIT)
  )
`endif
  u_grant (
`ifdef MEM_ARB_STARVE_GUARD_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .accept_i  (accept_s),
`endif
    .i_valid_i (i_bus.req_valid),
    .d_valid_i (d_bus.req_valid),
    .grant_i_o (grant_i_s),
    .grant_d_o (grant_d_s)
  );

  // Readies stay low until the first clock after reset so all outputs are 0 in reset.
  assign accept_s = (state_q == IDLE) & arb_en_q & (grant_i_s | grant_d_s);

  // Arbitration enable, set on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_en_q <= 1'b0;
    end else begin
      arb_en_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = ISSUE;
        else          state_d = IDLE;
      end
      ISSUE: begin
        if (mem_bus.req_ready) state_d = WAIT;
        else                   state_d = ISSUE;
      end
      WAIT: begin
        if (mem_bus.resp_valid) state_d = IDLE;
        else                    state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshakes, memory request and response routing.
  always_comb begin
    i_bus.req_ready    = accept_s & grant_i_s;
    d_bus.req_ready    = accept_s & grant_d_s;
    mem_bus.req_valid  = (state_q == ISSUE);
    mem_bus.req_we     = we_q;
    mem_bus.req_addr   = addr_q;
    mem_bus.req_wdata  = wdata_q;
    i_bus.resp_valid   = mem_bus.resp_valid & (state_q == WAIT) & (txn_owner_q == MEM_ARB_OWNER_I);
    d_bus.resp_valid   = mem_bus.resp_valid & (state_q == WAIT) & (txn_owner_q == MEM_ARB_OWNER_D);
    i_bus.resp_data    = mem_bus.resp_data;
    d_bus.resp_data    = mem_bus.resp_data;
    owner_d            = txn_owner_q;
  end

  // Capture selection: I requests are always reads and carry no write data.
  always_comb begin
    txn_owner_d = txn_owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (accept_s && grant_d_s) begin
      txn_owner_d = MEM_ARB_OWNER_D;
      we_d        = d_bus.req_we;
      addr_d      = d_bus.req_addr;
      wdata_d     = d_bus.req_wdata;
    end else if (accept_s) begin
      txn_owner_d = MEM_ARB_OWNER_I;
      we_d        = 1'b0;
      addr_d      = i_bus.req_addr;
      wdata_d     = {LINE_W{1'b0}};
    end else begin
      txn_owner_d = txn_owner_q;
    end
  end

  // Capture registers holding the outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_owner_q <= MEM_ARB_OWNER_I;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {LINE_W{1'b0}};
    end else begin
      txn_owner_q <= txn_owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and routed
// responses are queued at stimulus time and compared when they appear.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int SL = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic          owner;
    logic [LW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic owner_d;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) i_if ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) d_if ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) m_if ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(SL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_bus   (i_if),
    .d_bus   (d_if),
    .mem_bus (m_if),
    .owner_d (owner_d)
  );

  int passed = 0;
  int total  = 0;
  req_t  req_q[$];
  resp_t resp_q[$];

  bit            mm_auto = 1'b1;
  int            rd_delay = 0;
  int            resp_delay = 1;
  int            mm_state = 0;
  int            mm_cnt = 0;
  logic [AW-1:0] mm_addr;
  logic          man_ready = 1'b0;
  logic          man_resp = 1'b0;
  logic [LW-1:0] man_data = '0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {32'hDEAD_0000, a, ~a, 32'h0000_BEEF};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mm_accept();
    req_t e;
    req_t o;
    m_if.req_ready = 1'b1;
    mm_addr  = m_if.req_addr;
    mm_cnt   = resp_delay;
    mm_state = 2;
    o = '{we: m_if.req_we, addr: m_if.req_addr, wdata: m_if.req_wdata};
    total++;
    if (req_q.size() == 0) begin
      $display("FAIL mem_req_unexpected: got we=%0b addr=%h, none expected", o.we, o.addr);
    end else begin
      e = req_q.pop_front();
      if (o !== e) $display("FAIL mem_req: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                            o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
      else passed++;
    end
  endtask

  // Memory model: automatic mode follows rd_delay/resp_delay, manual mode copies man_*.
  initial begin
    m_if.req_ready  = 1'b0;
    m_if.resp_valid = 1'b0;
    m_if.resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!mm_auto) begin
        m_if.req_ready  = man_ready;
        m_if.resp_valid = man_resp;
        m_if.resp_data  = man_data;
        mm_state = 0;
      end else begin
        m_if.req_ready  = 1'b0;
        m_if.resp_valid = 1'b0;
        case (mm_state)
          0: if (m_if.req_valid) begin
               if (rd_delay == 0) mm_accept();
               else begin mm_cnt = rd_delay; mm_state = 1; end
             end
          1: begin mm_cnt--; if (mm_cnt == 0) mm_accept(); end
          2: begin
               mm_cnt--;
               if (mm_cnt == 0) begin
                 m_if.resp_valid = 1'b1;
                 m_if.resp_data  = line_of(mm_addr);
                 mm_state = 0;
               end
             end
          default: mm_state = 0;
        endcase
      end
    end
  end

  // Response monitor: every routed response is popped against the scoreboard.
  always @(negedge clk) begin
    resp_t e;
    resp_t o;
    if (i_if.resp_valid || d_if.resp_valid) begin
      o.owner = d_if.resp_valid;
      o.data  = d_if.resp_valid ? d_if.resp_data : i_if.resp_data;
      total++;
      if (resp_q.size() == 0) begin
        $display("FAIL resp_unexpected: got i=%0b d=%0b data=%h, none expected",
                 i_if.resp_valid, d_if.resp_valid, o.data);
      end else begin
        e = resp_q.pop_front();
        if ((i_if.resp_valid && d_if.resp_valid) || (o !== e))
          $display("FAIL resp: got i=%0b d=%0b data=%h, want owner_d=%0b data=%h",
                   i_if.resp_valid, d_if.resp_valid, o.data, e.owner, e.data);
        else passed++;
      end
    end
  end

  task automatic wait_grant(output bit got_d, output bit ok);
    ok = 1'b0;
    got_d = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (i_if.req_ready || d_if.req_ready) begin
        ok = 1'b1;
        got_d = d_if.req_ready;
        break;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL grant_timeout: got no ready in 64 cycles, want one");
    end
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (resp_q.size() == 0 && req_q.size() == 0 && mm_state == 0) break;
    end
    total++;
    if (resp_q.size() != 0 || req_q.size() != 0)
      $display("FAIL drain: got %0d resp / %0d req pending, want 0", resp_q.size(), req_q.size());
    else passed++;
    step();
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    rst_n = 1'b0;
    i_if.req_valid = 1'b1; i_if.req_we = 1'b0; i_if.req_addr = 32'h0000_0100; i_if.req_wdata = '0;
    d_if.req_valid = 1'b1; d_if.req_we = 1'b1; d_if.req_addr = 32'h0000_0200; d_if.req_wdata = '1;
    @(negedge clk);
    flags = {i_if.req_ready, d_if.req_ready, i_if.resp_valid, d_if.resp_valid,
             m_if.req_valid, m_if.req_we, owner_d};
    total++;
    if (flags !== 7'd0) $display("FAIL reset_flags: got %b, want 0000000", flags);
    else passed++;
    total++;
    if ({m_if.req_addr, m_if.req_wdata} !== {AW'(0), LW'(0)})
      $display("FAIL reset_payload: got addr=%h wdata=%h, want 0", m_if.req_addr, m_if.req_wdata);
    else passed++;
    i_if.req_valid = 1'b0;
    d_if.req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_i_read();
    bit got_d, ok;
    rd_delay = 0; resp_delay = 1;
    req_q.push_back('{we: 1'b0, addr: 32'h0000_1000, wdata: '0});
    resp_q.push_back('{owner: MEM_ARB_OWNER_I, data: line_of(32'h0000_1000)});
    i_if.req_valid = 1'b1; i_if.req_addr = 32'h0000_1000;
    @(negedge clk);
    total++;
    if ({i_if.req_ready, d_if.req_ready} !== 2'b10)
      $display("FAIL i_grant: got i/d ready=%b, want 10", {i_if.req_ready, d_if.req_ready});
    else passed++;
    step();
    i_if.req_addr = 32'h0000_2000;
    req_q.push_back('{we: 1'b0, addr: 32'h0000_2000, wdata: '0});
    resp_q.push_back('{owner: MEM_ARB_OWNER_I, data: line_of(32'h0000_2000)});
    @(negedge clk);
    total++;
    if ({m_if.req_valid, i_if.req_ready, owner_d} !== 3'b100)
      $display("FAIL i_issue: got valid/ready/owner=%b, want 100", {m_if.req_valid, i_if.req_ready, owner_d});
    else passed++;
    step();
    @(negedge clk);
    total++;
    if ({i_if.resp_valid, d_if.resp_valid, i_if.req_ready} !== 3'b100)
      $display("FAIL i_resp_route: got i/d resp, ready=%b, want 100",
               {i_if.resp_valid, d_if.resp_valid, i_if.req_ready});
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (i_if.req_ready !== 1'b1) $display("FAIL i_idle_t3: got ready=%b, want 1", i_if.req_ready);
    else passed++;
    step();
    i_if.req_valid = 1'b0;
    drain();
    if (!ok && got_d) step();
  endtask

  task automatic test_d_write();
    bit got_d, ok;
    logic [LW-1:0] wd;
    req_t exp_r;
    wd = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    rd_delay = 5; resp_delay = 1;
    exp_r = '{we: 1'b1, addr: 32'h8000_0040, wdata: wd};
    req_q.push_back(exp_r);
    resp_q.push_back('{owner: MEM_ARB_OWNER_D, data: line_of(32'h8000_0040)});
    d_if.req_valid = 1'b1; d_if.req_we = 1'b1; d_if.req_addr = 32'h8000_0040; d_if.req_wdata = wd;
    wait_grant(got_d, ok);
    total++;
    if (got_d !== 1'b1) $display("FAIL d_grant: got d=%b, want 1", got_d);
    else passed++;
    d_if.req_valid = 1'b0; d_if.req_addr = '0; d_if.req_wdata = '0; d_if.req_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({m_if.req_valid, m_if.req_we, m_if.req_addr, m_if.req_wdata, owner_d} !== {1'b1, exp_r, 1'b1})
        $display("FAIL d_hold_c%0d: got v=%b we=%b addr=%h owner=%b, want 1 1 %h 1",
                 c, m_if.req_valid, m_if.req_we, m_if.req_addr, owner_d, exp_r.addr);
      else passed++;
      step();
    end
    @(negedge clk);
    total++;
    if (m_if.req_valid !== 1'b0) $display("FAIL d_wait: got mem_req_valid=%b, want 0", m_if.req_valid);
    else passed++;
    step();
    rd_delay = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    bit got_d, ok;
    req_q.push_back('{we: 1'b0, addr: 32'h0000_7000, wdata: '0});
    resp_q.push_back('{owner: MEM_ARB_OWNER_D, data: line_of(32'h0000_7000)});
    req_q.push_back('{we: 1'b0, addr: 32'h0000_6000, wdata: '0});
    resp_q.push_back('{owner: MEM_ARB_OWNER_I, data: line_of(32'h0000_6000)});
    i_if.req_valid = 1'b1; i_if.req_addr = 32'h0000_6000;
    d_if.req_valid = 1'b1; d_if.req_we = 1'b0; d_if.req_addr = 32'h0000_7000;
    wait_grant(got_d, ok);
    total++;
    if (got_d !== 1'b1) $display("FAIL tie_d_first: got d=%b, want 1", got_d);
    else passed++;
    d_if.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (i_if.req_ready !== 1'b0) $display("FAIL tie_i_wait1: got ready=%b, want 0", i_if.req_ready);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if ({i_if.req_ready, d_if.resp_valid} !== 2'b01)
      $display("FAIL tie_i_wait2: got ready/dresp=%b, want 01", {i_if.req_ready, d_if.resp_valid});
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (i_if.req_ready !== 1'b1) $display("FAIL tie_i_next: got ready=%b, want 1", i_if.req_ready);
    else passed++;
    step();
    i_if.req_valid = 1'b0;
    drain();
  endtask

  task automatic test_starvation();
    bit got_d, ok;
    logic exp_d;
    for (int k = 0; k < 10; k++) begin
      exp_d = GUARD ? ((k % (SL + 1)) != SL) : 1'b1;
      req_q.push_back('{we: 1'b0, addr: exp_d ? 32'h0000_5000 : 32'h0000_4000, wdata: '0});
      resp_q.push_back('{owner: exp_d, data: line_of(exp_d ? 32'h0000_5000 : 32'h0000_4000)});
    end
    i_if.req_valid = 1'b1; i_if.req_addr = 32'h0000_4000;
    d_if.req_valid = 1'b1; d_if.req_we = 1'b0; d_if.req_addr = 32'h0000_5000;
    for (int k = 0; k < 10; k++) begin
      exp_d = GUARD ? ((k % (SL + 1)) != SL) : 1'b1;
      wait_grant(got_d, ok);
      if (ok) begin
        total++;
        if (got_d !== exp_d) $display("FAIL starve_order_%0d: got d=%b, want %b", k, got_d, exp_d);
        else passed++;
      end
    end
    i_if.req_valid = 1'b0;
    d_if.req_valid = 1'b0;
    drain();
  endtask

  task automatic test_spurious();
    bit got_d, ok;
    mm_auto = 1'b0; man_ready = 1'b0; man_resp = 1'b0;
    step();
    man_resp = 1'b1; man_data = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    total++;
    if ({i_if.resp_valid, d_if.resp_valid, m_if.req_valid} !== 3'b000)
      $display("FAIL spur_idle: got i/d resp, mem valid=%b, want 000",
               {i_if.resp_valid, d_if.resp_valid, m_if.req_valid});
    else passed++;
    step();
    man_resp = 1'b0;
    resp_q.push_back('{owner: MEM_ARB_OWNER_D, data: line_of(32'h0000_9000)});
    d_if.req_valid = 1'b1; d_if.req_we = 1'b0; d_if.req_addr = 32'h0000_9000;
    wait_grant(got_d, ok);
    total++;
    if (got_d !== 1'b1) $display("FAIL spur_still_idle: got d=%b, want 1", got_d);
    else passed++;
    d_if.req_valid = 1'b0;
    man_resp = 1'b1;
    @(negedge clk);
    total++;
    if ({i_if.resp_valid, d_if.resp_valid, m_if.req_valid} !== 3'b001)
      $display("FAIL spur_issue: got i/d resp, mem valid=%b, want 001",
               {i_if.resp_valid, d_if.resp_valid, m_if.req_valid});
    else passed++;
    step();
    man_resp = 1'b0; man_ready = 1'b1;
    @(negedge clk);
    total++;
    if (m_if.req_valid !== 1'b1) $display("FAIL spur_stay_issue: got valid=%b, want 1", m_if.req_valid);
    else passed++;
    step();
    man_ready = 1'b0; man_resp = 1'b1; man_data = line_of(32'h0000_9000);
    @(negedge clk);
    total++;
    if ({i_if.resp_valid, d_if.resp_valid} !== 2'b01)
      $display("FAIL spur_real_resp: got i/d resp=%b, want 01", {i_if.resp_valid, d_if.resp_valid});
    else passed++;
    step();
    man_resp = 1'b0;
    @(negedge clk);
    total++;
    if ({d_if.resp_valid, m_if.req_valid} !== 2'b00)
      $display("FAIL spur_done: got dresp/valid=%b, want 00", {d_if.resp_valid, m_if.req_valid});
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    bit got_d, ok;
    logic [6:0] flags;
    i_if.req_valid = 1'b1; i_if.req_addr = 32'h0000_A000;
    wait_grant(got_d, ok);
    i_if.req_valid = 1'b0;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    rst_n = 1'b0;
    man_resp = 1'b1; man_data = line_of(32'h0000_A000);
    @(negedge clk);
    flags = {i_if.req_ready, d_if.req_ready, i_if.resp_valid, d_if.resp_valid,
             m_if.req_valid, m_if.req_we, owner_d};
    total++;
    if (flags !== 7'd0) $display("FAIL midrst_flags: got %b, want 0000000", flags);
    else passed++;
    total++;
    if (m_if.req_addr !== AW'(0)) $display("FAIL midrst_addr: got %h, want 0", m_if.req_addr);
    else passed++;
    step();
    man_resp = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    man_resp = 1'b1;
    @(negedge clk);
    total++;
    if ({i_if.resp_valid, d_if.resp_valid, m_if.req_valid} !== 3'b000)
      $display("FAIL midrst_no_resp: got i/d resp, valid=%b, want 000",
               {i_if.resp_valid, d_if.resp_valid, m_if.req_valid});
    else passed++;
    step();
    man_resp = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_back_to_back();
    test_starvation();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path. It accepts one transaction at a time from either requester over a valid/ready handshake and forwards it to memory. It routes the memory response back to the owner. While a requester's transaction is outstanding, its cache keeps its data-valid signal low, and the hazard logic stalls fetch or decode.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_W`, 128, cache-line width in bits
- `STARVE_LIMIT`, 4, maximum consecutive D grants while I is waiting (only used with the guard; ≥1)
---
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `i_req_valid` in 1 / `i_req_ready` out 1 / `i_req_addr` in ADDR_W: I-cache read request
- `i_resp_valid` out 1 / `i_resp_data` out LINE_W: I-cache refill response
- `d_req_valid` in 1 / `d_req_ready` out 1 / `d_req_we` in 1 / `d_req_addr` in ADDR_W / `d_req_wdata` in LINE_W: D-cache request (we=1 means write-back)
- `d_resp_valid` out 1 / `d_resp_data` out LINE_W: D-cache response (write acknowledge when we=1)
- `mem_req_valid` out 1 / `mem_req_ready` in 1 / `mem_req_we` out 1 / `mem_req_addr` out ADDR_W / `mem_req_wdata` out LINE_W: memory request
- `mem_resp_valid` in 1 / `mem_resp_data` in LINE_W: memory response, one pulse per request, reads and writes alike
- `owner_d` out 1: current transaction belongs to D (debug/perf)

## Operation
- FSM states:
  - IDLE: arbitrate; `x_req_ready` is combinational and asserted only to the granted requester.
  - ISSUE: hold `mem_req_*` from the capture registers; go to WAIT on `mem_req_ready`.
  - WAIT: go to IDLE on `mem_resp_valid`.
- Grant in IDLE:
  - D only valid → D; I only valid → I.
  - Both valid → D, unless the starvation guard forces I.
- Handshake: on `x_req_valid & x_req_ready`, capture addr, we (forced 0 for I), wdata and owner; next state ISSUE.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is legal, and the arbitration that cycle simply excludes that requester.
- Response routing:
  - `i_resp_valid = mem_resp_valid & state==WAIT & ~owner_d`.
  - `d_resp_valid` likewise with `owner_d`.
  - Both resp_data ports are a combinational pass-through of `mem_resp_data`.
- Any `mem_resp_valid` outside WAIT is ignored.
- Exactly one transaction is outstanding; both readies are 0 outside IDLE.
- Address and data are passed unmodified, no width conversion.

## Timing
- Reset value of every output is 0: all valid/ready, `mem_req_*` payload, `owner_d`.
- On reset, state is IDLE and the starvation counter is 0.
- Reset mid-transaction: the transaction is dropped immediately (asynchronous) and no response is delivered afterward.
- Minimum round trip, with acceptance in cycle T:
  - `mem_req_valid` is first high in T+1.
  - If mem is ready in T+1 and responds in T+2, `x_resp_valid` is high in T+2.
  - IDLE in T+3, and the next acceptance is possible in T+3.
- `mem_req_valid` stays high from entry into ISSUE until the cycle of `mem_req_ready` inclusive; payload is stable throughout.
- A response arriving in the same cycle as `mem_req_ready` is not legal for memory; the arbiter does not need to handle it.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter, $clog2(STARVE_LIMIT+1) bits, increments on each D grant made while `i_req_valid`=1.
  - When counter==STARVE_LIMIT and both requesters are valid, I is granted.
  - The counter clears on any I grant.
- Not defined: strict D-over-I priority, and no counter is instantiated.

## Structure
- `mem_arb_pkg` holds:
  - the state enum `mem_arb_state_t` (IDLE, ISSUE, WAIT);
  - `MEM_ARB_OWNER_I`/`MEM_ARB_OWNER_D` constants;
  - default `ADDR_W`/`LINE_W` localparams.
- Sub-module `mem_arb_grant` holds the combinational grant selection plus the starvation counter under the macro.
- The top-level `mem_arbiter` holds the FSM, capture registers and response routing.

## Test plan
- I read alone, addr 0x0000_1000, mem ready immediately, response 0xDEAD…BEEF after 1 cycle → `i_resp_valid` pulses 1 cycle with that data; `d_resp_valid` stays 0; IDLE 3 cycles after acceptance.
- D write-back addr 0x8000_0040, wdata 0x1234…, `mem_req_ready` delayed 5 cycles → `mem_req_*` stable for 6 cycles with we=1; ack routed to D only.
- I and D valid in the same cycle → D is granted first, I waits; I is granted in the IDLE cycle after D's response.
- With the guard, STARVE_LIMIT=4, D and I continuously valid → grant order D,D,D,D,I,D,D,D,D,I. Without the macro → D only.
- `rst_n` low while in WAIT, then `mem_resp_valid` pulsed after release → no resp_valid on either side; all outputs 0 during reset.
- Spurious `mem_resp_valid` in IDLE and in ISSUE → ignored; no state change, no response outputs.
